// File: rtl/uart_receiver.sv
// UART receiver: oversampled start/data/parity/stop framing with error flags.
// Latency: data_valid one cycle after the mid-stop-bit sample; 2 extra input cycles with UART_RX_SYNC_EN.
// Backpressure: none; data_valid is a one-cycle pulse and data_out/flags hold until the next frame.
// Optional macro UART_RX_SYNC_EN: two-flop synchronizer on serial_in (default: line used directly).
module uart_receiver #(
    parameter int COUNTS_PER_BIT  = 434,
    parameter int DATA_BITS       = 8,
    parameter int CLOCK_CTR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic [1:0]           parity_type,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 busy
);

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } state_t;

    // Sample points: half a bit into the start bit, then once per full bit period.
    localparam logic [CLOCK_CTR_WIDTH-1:0] CTR_HALF = CLOCK_CTR_WIDTH'(COUNTS_PER_BIT / 2 - 1);
    localparam logic [CLOCK_CTR_WIDTH-1:0] CTR_FULL = CLOCK_CTR_WIDTH'(COUNTS_PER_BIT - 1);
    localparam logic [4:0]                 LAST_IDX = 5'(DATA_BITS - 1);

    state_t                     state;
    logic [CLOCK_CTR_WIDTH-1:0] clock_ctr;
    logic [4:0]                 bit_idx;
    logic [DATA_BITS-1:0]       shift_reg;
    logic [DATA_BITS-1:0]       shift_nxt;
    logic [1:0]                 par_mode;
    logic                       par_err_pend;
    logic                       par_exp;
    logic                       rx_s;
    logic                       ctr_half;
    logic                       ctr_full;

`ifdef UART_RX_SYNC_EN
    logic sync_1;
    logic sync_2;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= serial_in;
            sync_2 <= sync_1;
        end
    end

    assign rx_s = sync_2;
`else
    assign rx_s = serial_in;
`endif

    assign ctr_half = (clock_ctr == CTR_HALF);
    assign ctr_full = (clock_ctr == CTR_FULL);
    assign busy     = (state != RX_IDLE);

    // Expected parity bit from the fully shifted payload (odd: 1 when the payload has an even count of ones).
    assign par_exp = (par_mode == 2'd1) ? ~^shift_reg : ^shift_reg;

    // Next payload value: LSB-first, so the new sample enters at the top.
    always_comb begin
        shift_nxt                = shift_reg >> 1;
        shift_nxt[DATA_BITS-1]   = rx_s;
    end

    // Receive FSM with bit timing, payload shifting and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RX_IDLE;
            clock_ctr     <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            par_mode      <= 2'd0;
            par_err_pend  <= 1'b0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    // Parity mode is tracked while idle and frozen once a frame starts.
                    par_mode     <= (parity_type == 2'd3) ? 2'd0 : parity_type;
                    clock_ctr    <= '0;
                    bit_idx      <= '0;
                    par_err_pend <= 1'b0;
                    if (!rx_s) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (ctr_half) begin
                        clock_ctr <= '0;
                        // A line already back high mid start bit was a glitch.
                        state     <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        clock_ctr <= clock_ctr + CLOCK_CTR_WIDTH'(1);
                    end
                end
                RX_DATA: begin
                    if (ctr_full) begin
                        clock_ctr <= '0;
                        shift_reg <= shift_nxt;
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
                            state   <= (par_mode == 2'd1 || par_mode == 2'd2) ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 5'd1;
                        end
                    end else begin
                        clock_ctr <= clock_ctr + CLOCK_CTR_WIDTH'(1);
                    end
                end
                RX_PARITY: begin
                    if (ctr_full) begin
                        clock_ctr    <= '0;
                        par_err_pend <= (rx_s != par_exp);
                        state        <= RX_STOP;
                    end else begin
                        clock_ctr <= clock_ctr + CLOCK_CTR_WIDTH'(1);
                    end
                end
                RX_STOP: begin
                    if (ctr_full) begin
                        // Payload is delivered even when a flag is raised.
                        clock_ctr     <= '0;
                        data_out      <= shift_reg;
                        parity_error  <= par_err_pend;
                        framing_error <= ~rx_s;
                        data_valid    <= 1'b1;
                        state         <= RX_IDLE;
                    end else begin
                        clock_ctr <= clock_ctr + CLOCK_CTR_WIDTH'(1);
                    end
                end
                default: begin
                    state     <= RX_IDLE;
                    clock_ctr <= '0;
                    bit_idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter COUNTS_PER_BIT, default 434, meaning clk cycles per serial bit (min 4).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (1..16).
REQ-003 The block SHALL have parameter CLOCK_CTR_WIDTH, default 32, meaning width of the bit-timing counter.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit, with reset synchronous and active-high.
REQ-006 The block SHALL have port serial_in, input, 1 bit, the asynchronous UART line (idle high), typically driven by the transmitter's serial_out.
REQ-007 The block SHALL have port parity_type, input, 2 bits: 0 none, 1 odd, 2 even, 3 treated as none.
REQ-008 The block SHALL have port data_out, output, DATA_BITS wide, the last received payload.
REQ-009 The block SHALL have port data_valid, output, 1 bit, a one-cycle pulse when data_out/error flags are updated.
REQ-010 The block SHALL have port parity_error, output, 1 bit, set when the received parity bit mismatches.
REQ-011 The block SHALL have port framing_error, output, 1 bit, set when the stop-bit sample is 0.
REQ-012 The block SHALL have port busy, output, 1 bit, high whenever the state is not RX_IDLE.

Function
REQ-013 The FSM SHALL have states RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP; any illegal encoding SHALL go to RX_IDLE next cycle.
REQ-014 In RX_IDLE the block SHALL latch parity_type into an internal register every cycle, mapping 3 to 0; the value SHALL be frozen for the rest of the frame.
REQ-015 In RX_IDLE, sampled line (rx_s) = 0 SHALL move to RX_START with clock_ctr = 0; this cycle is t0.
REQ-016 In RX_START, at clock_ctr = COUNTS_PER_BIT/2 - 1 (integer division), rx_s = 0 SHALL go to RX_DATA (ctr cleared, bit index 0); rx_s = 1 SHALL be treated as a glitch and return to RX_IDLE with no data_valid.
REQ-017 In RX_DATA, RX_PARITY and RX_STOP, the line SHALL be sampled when clock_ctr = COUNTS_PER_BIT - 1, then clock_ctr cleared; otherwise clock_ctr increments.
REQ-018 RX_DATA SHALL shift in DATA_BITS samples LSB first; after the last one it SHALL go to RX_PARITY if latched parity is 1 or 2, else RX_STOP.
REQ-019 RX_PARITY SHALL compute expected bit: odd = ~^payload, even = ^payload; mismatch SHALL set the pending parity error.
REQ-020 On the RX_STOP sample the block SHALL, in the next cycle, load data_out, parity_error and framing_error (stop sample = 0), pulse data_valid for exactly one cycle, and enter RX_IDLE.
REQ-021 The payload SHALL be delivered even when either error flag is set; flags SHALL hold until the next data_valid.
REQ-022 data_valid SHALL rise at cycle t0 + COUNTS_PER_BIT/2 + N*COUNTS_PER_BIT + 1, with N = DATA_BITS + P + 1 and P = 1 if parity is enabled, else 0.
REQ-023 The block SHALL accept back-to-back frames: a start bit beginning at the second half of the previous stop bit SHALL be detected.
REQ-024 parity_type changes mid-frame SHALL have no effect on the current frame.

Reset
REQ-025 rst = 1 at a clock edge SHALL force RX_IDLE and set clock_ctr = 0, bit index = 0, data_out = 0, data_valid = 0, parity_error = 0, framing_error = 0, busy = 0, and latched parity = 0; the synchronizer flops SHALL be set to 1.
REQ-026 Reset mid-frame SHALL abort the frame with no data_valid, and reception SHALL restart at the next falling edge after rst deasserts.

Configuration
REQ-027 With macro UART_RX_SYNC_EN defined, rx_s SHALL be serial_in passed through a two-flop synchronizer (adds 2 cycles to t0 relative to the line edge).
REQ-028 Without UART_RX_SYNC_EN, rx_s SHALL be serial_in directly (input assumed synchronous to clk); all cycle counts relative to t0 SHALL be unchanged.

Verification (COUNTS_PER_BIT = 16, DATA_BITS = 8)
REQ-029 No parity, frame 0xA5, stop 1 -> data_out = 0xA5, data_valid pulse at t0 + 8 + 144 + 1, both errors 0.
REQ-030 Even parity, 0x03 with parity bit 0 -> parity_error 0; repeat with parity bit 1 -> data_out = 0x03, parity_error 1.
REQ-031 Odd parity, 0x00 with stop bit forced 0 -> data_out = 0x00, framing_error 1, parity_error 0.
REQ-032 3-cycle low glitch on idle line -> return to RX_IDLE, no data_valid, busy high for 8 cycles only.
REQ-033 Two back-to-back frames 0x55, 0xAA with 1 stop bit each -> two data_valid pulses 160 cycles apart, correct data.
REQ-034 rst asserted mid-RX_DATA -> all outputs 0 the next cycle; a subsequent frame 0x3C is received correctly.
